// File: rtl/wb_debounced_inputs_pkg.sv
// Register map indices shared by the debounced-input block and its users.
package debounce_pkg;

  // Word index carried on adr[4:2]; indices 5..7 are reserved and read as zero.
  typedef enum logic [2:0] {
    REG_STATE   = 3'd0,
    REG_PENDING = 3'd1,
    REG_MASK    = 3'd2,
    REG_RISE_EN = 3'd3,
    REG_FALL_EN = 3'd4
  } reg_idx_e;

endpackage

// File: rtl/wb_debounced_inputs_cell.sv
// One input channel: 2-flop synchronizer, stability counter, debounced level.
// o_rise/o_fall are high in the cycle whose closing edge updates the level,
// so an edge event and the level change land on the same clock edge.
module debounce_cell #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // Synchronizer, counter and debounced level registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_pin;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count while the synchronized pin disagrees with the level; any agreement restarts.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
      accept  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign o_level = level_q;
  assign o_rise  = accept &  sync2_q;
  assign o_fall  = accept & ~sync2_q;

endmodule

// File: rtl/wb_debounced_inputs.sv
// Wishbone slave exposing debounced inputs with per-input edge-triggered
// pending flags, mask and edge selection, and one level interrupt output.
module wb_debounced_inputs
  import debounce_pkg::*;
#(
  parameter int unsigned N_INPUTS        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          i_wb_adr,
  input  logic [31:0]         i_wb_dat,
  input  logic                i_wb_we,
  input  logic                i_wb_stb,
  input  logic                i_wb_cyc,
  output logic [31:0]         o_wb_dat,
  output logic                o_wb_ack,
  output logic                o_wb_err,
  output logic                o_wb_rty,
  input  logic [N_INPUTS-1:0] i_inputs,
  output logic                o_int
);

  logic [N_INPUTS-1:0] level, rise, fall;
  logic [N_INPUTS-1:0] pend_q, pend_d;
  logic [N_INPUTS-1:0] mask_q, mask_d;
  logic [N_INPUTS-1:0] rise_en_q, rise_en_d;
  logic [N_INPUTS-1:0] fall_en_q, fall_en_d;
  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic [31:0]         rdata;
  logic [N_INPUTS-1:0] wdat;
  logic [2:0]          idx;
  logic                req, wr;
  logic                unused_bits;

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .i_pin  (i_inputs[g]),
      .o_level(level[g]),
      .o_rise (rise[g]),
      .o_fall (fall[g])
    );
  end

  assign idx  = i_wb_adr[4:2];
  assign wdat = i_wb_dat[N_INPUTS-1:0];
  assign req  = i_wb_cyc & i_wb_stb & ~ack_q;
  assign wr   = req & i_wb_we;

  assign unused_bits = ^{i_wb_adr[1:0], i_wb_dat};

  // Read mux over pre-edge state; upper bits stay zero.
  always_comb begin
    rdata = '0;
    case (idx)
      REG_STATE:   rdata[N_INPUTS-1:0] = level;
      REG_PENDING: rdata[N_INPUTS-1:0] = pend_q;
      REG_MASK:    rdata[N_INPUTS-1:0] = mask_q;
      REG_RISE_EN: rdata[N_INPUTS-1:0] = rise_en_q;
      REG_FALL_EN: rdata[N_INPUTS-1:0] = fall_en_q;
      default:     rdata = '0;
    endcase
  end

  // Register writes, W1C clear, then edge events OR-ed in so a same-cycle event wins.
  always_comb begin
    ack_d     = req;
    dat_d     = (req & ~i_wb_we) ? rdata : '0;
    mask_d    = mask_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    pend_d    = pend_q;
    if (wr) begin
      case (idx)
        REG_PENDING: pend_d    = pend_q & ~wdat;
        REG_MASK:    mask_d    = wdat;
        REG_RISE_EN: rise_en_d = wdat;
        REG_FALL_EN: fall_en_d = wdat;
        default:     ;
      endcase
    end
    pend_d = pend_d | (rise & rise_en_q) | (fall & fall_en_q);
  end

  // Control/status registers and the registered bus response.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q    <= '0;
      mask_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_dat = dat_q;
  assign o_wb_err = 1'b0;
  assign o_wb_rty = 1'b0;
  assign o_int    = |(pend_q & mask_q);

endmodule

// File: tb/tb_wb_debounced_inputs.sv
// Directed bench for wb_debounced_inputs with DEBOUNCE_CYCLES=4, N_INPUTS=3.
module tb_wb_debounced_inputs;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic        i_wb_we, i_wb_stb, i_wb_cyc;
  logic [31:0] o_wb_dat;
  logic        o_wb_ack, o_wb_err, o_wb_rty;
  logic [2:0]  i_inputs;
  logic        o_int;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] rd;

  wb_debounced_inputs #(
    .N_INPUTS(3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_wb_adr(i_wb_adr),
    .i_wb_dat(i_wb_dat),
    .i_wb_we (i_wb_we),
    .i_wb_stb(i_wb_stb),
    .i_wb_cyc(i_wb_cyc),
    .o_wb_dat(o_wb_dat),
    .o_wb_ack(o_wb_ack),
    .o_wb_err(o_wb_err),
    .o_wb_rty(o_wb_rty),
    .i_inputs(i_inputs),
    .o_int   (o_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the ack edge.
  task automatic wb_xfer(input logic we, input logic [2:0] idx, input logic [31:0] wd,
                         output logic [31:0] data);
    int unsigned n;
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_we  = we;
    i_wb_adr = {idx, 2'b00};
    i_wb_dat = wd;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!o_wb_ack && n < 4);
    chk("ack", {31'd0, o_wb_ack}, 32'd1);
    data     = o_wb_dat;
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] idx, input logic [31:0] wd);
    logic [31:0] dummy;
    wb_xfer(1'b1, idx, wd, dummy);
  endtask

  task automatic wb_read(input logic [2:0] idx, output logic [31:0] data);
    wb_xfer(1'b0, idx, 32'd0, data);
  endtask

  initial begin
    reset = 1'b1; i_inputs = 3'b000;
    i_wb_adr = '0; i_wb_dat = '0; i_wb_we = 1'b0; i_wb_stb = 1'b0; i_wb_cyc = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("rst_dat", o_wb_dat, 32'd0);
    chk("rst_int", {31'd0, o_int}, 32'd0);
    chk("rst_err_rty", {30'd0, o_wb_err, o_wb_rty}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    wb_read(3'd0, rd);  chk("rst_state", rd, 32'd0);
    wb_read(3'd2, rd);  chk("rst_mask", rd, 32'd0);

    // Clean press on input0: level and interrupt at edge 6
    wb_write(3'd2, 32'h7);
    @(negedge clk);
    chk("ack_single", {31'd0, o_wb_ack}, 32'd0);
    wb_write(3'd3, 32'h1);
    wb_read(3'd3, rd);  chk("rise_en_rb", rd, 32'd1);
    i_inputs[0] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("press_int_e5", {31'd0, o_int}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("press_int_e6", {31'd0, o_int}, 32'd1);
    wb_read(3'd0, rd);  chk("press_state", rd, 32'd1);
    wb_read(3'd1, rd);  chk("press_pending", rd, 32'd1);

    // W1C
    wb_write(3'd1, 32'h0);
    wb_read(3'd1, rd);  chk("w1c_zero", rd, 32'd1);
    wb_write(3'd1, 32'h1);
    chk("w1c_int", {31'd0, o_int}, 32'd0);
    wb_read(3'd1, rd);  chk("w1c_pending", rd, 32'd0);

    // Bounce on input1 (rising; only FALL_EN bit1 set)
    wb_write(3'd4, 32'h2);
    @(negedge clk);
    i_inputs[1] = 1'b1;           // before e1
    repeat (3) @(negedge clk);
    i_inputs[1] = 1'b0;           // before e4
    @(negedge clk);
    i_inputs[1] = 1'b1;           // before e5; s rises at e6, d at e10
    repeat (4) @(negedge clk);    // before e9
    @(negedge clk);               // before e10
    wb_read(3'd0, rd);  chk("bounce_state_e10", rd, 32'd1);
    wb_read(3'd0, rd);  chk("bounce_state_e12", rd, 32'd3);
    wb_read(3'd1, rd);  chk("bounce_pending", rd, 32'd0);
    chk("bounce_int", {31'd0, o_int}, 32'd0);

    // Collision: W1C of bit2 on the edge that sets it
    wb_write(3'd4, 32'h4);
    i_inputs[2] = 1'b1;
    repeat (10) @(negedge clk);
    wb_read(3'd0, rd);  chk("coll_state_hi", rd, 32'd7);
    i_inputs[2] = 1'b0;           // before e1; fall event at e6
    repeat (5) @(negedge clk);    // before e6
    wb_write(3'd1, 32'h4);
    chk("coll_int", {31'd0, o_int}, 32'd1);
    wb_read(3'd1, rd);  chk("coll_pending", rd, 32'd4);
    wb_write(3'd1, 32'h4);
    wb_read(3'd1, rd);  chk("coll_cleared", rd, 32'd0);

    // Mask: pending bit1 with MASK=0
    wb_write(3'd2, 32'h0);
    wb_write(3'd4, 32'h2);
    i_inputs[1] = 1'b0;
    repeat (8) @(negedge clk);
    chk("mask_int_off", {31'd0, o_int}, 32'd0);
    wb_read(3'd1, rd);  chk("mask_pending", rd, 32'd2);
    wb_write(3'd2, 32'h2);
    chk("mask_int_on", {31'd0, o_int}, 32'd1);
    wb_write(3'd2, 32'h0);
    wb_read(3'd1, rd);  chk("mask_keeps_pending", rd, 32'd2);
    wb_write(3'd5, 32'hffff_ffff);
    wb_read(3'd5, rd);  chk("reserved_read", rd, 32'd0);
    wb_read(3'd0, rd);  chk("state_upper", rd, 32'd1);

    // Reset mid-count on input2 (input0 still high)
    @(negedge clk);
    i_inputs[2] = 1'b1;           // before e1; cnt=2 after e4
    repeat (4) @(negedge clk);    // before e5
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("midrst_dat", o_wb_dat, 32'd0);
    chk("midrst_int", {31'd0, o_int}, 32'd0);
    reset = 1'b0;                 // before r1; d rises at r6
    repeat (5) @(negedge clk);    // before r6
    wb_read(3'd0, rd);  chk("midrst_state_r6", rd, 32'd0);
    wb_read(3'd0, rd);  chk("midrst_state_r8", rd, 32'd5);
    wb_read(3'd1, rd);  chk("midrst_pending", rd, 32'd0);
    chk("midrst_int_after", {31'd0, o_int}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_debounced_inputs.md
# wb_debounced_inputs

Debounced, edge-detecting input block for the board push-button and slide switches (key1, SW0, SW1). It sits directly upstream of the interrupt controller on the SoC Wishbone bus, in the same clock domain as the CPU. Per-input pending interrupt flags replace the single-switch slave. Software reads debounced levels, selects rising/falling edge sensitivity, masks inputs and clears pending flags over Wishbone. The block drives one level-sensitive interrupt line into one `i_brd_ints` bit of the interrupt controller.

## Interface
- `N_INPUTS`, 3: number of debounced inputs, 1..32.
- `DEBOUNCE_CYCLES`, 500000: stable cycles required before a level is accepted (10 ms at 50 MHz), ≥1.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES+1)`: counter width, derived; not overridden.
- `clk` in 1: single clock (wb_clk).
- `reset` in 1: synchronous, active-high.
- `i_wb_adr` in 5: byte address; bits [4:2] select the register.
- `i_wb_dat` in 32: write data.
- `i_wb_we` in 1: write enable.
- `i_wb_stb` in 1: strobe.
- `i_wb_cyc` in 1: cycle.
- `o_wb_dat` out 32: read data, valid with ack.
- `o_wb_ack` out 1: single-cycle acknowledge.
- `o_wb_err` out 1: tied 0.
- `o_wb_rty` out 1: tied 0.
- `i_inputs` in N_INPUTS: raw asynchronous pins.
- `o_int` out 1: `|(PENDING & MASK)`.

## Operation
- **Per-input path**
  - 2-flop synchronizer gives `s`. Debounced level is `d`.
  - Counter `cnt` behaviour:
    - If `s==d`: `cnt<=0`.
    - Else if `cnt==DEBOUNCE_CYCLES-1`: `d<=s` and `cnt<=0`.
    - Else: `cnt<=cnt+1`.
  - A bounce (`s` returning to `d`) before terminal count restarts the count from 0.
- **Edge event:** fires on the same edge that `d` updates.
  - Rising edge (0→1) is qualified by `RISE_EN[i]`.
  - Falling edge (1→0) is qualified by `FALL_EN[i]`.
- **Register map** (word index = `adr[4:2]`)
  - 0 STATE: RO, `d` vector.
  - 1 PENDING: W1C; writing 1 clears the bit, writing 0 has no effect.
  - 2 MASK: RW.
  - 3 RISE_EN: RW.
  - 4 FALL_EN: RW.
  - 5–7: read 0, writes ignored, still acked.
  - Bits ≥ N_INPUTS read 0.
- **Simultaneous events:** an edge event setting PENDING[i] wins over a W1C of the same bit in the same cycle. The bit stays 1.
- **Interrupt:** `o_int` is combinational from registered PENDING and MASK. It is glitch-free and stays high until software clears or masks the bit.
- **Mask and edge-enable writes:**
  - Masking does not clear PENDING.
  - Changing RISE_EN or FALL_EN does not generate events.
- **Reset values (all 0):** synchronizers, `d`, `cnt`, PENDING, MASK, RISE_EN, FALL_EN, `o_wb_ack`, `o_wb_dat`, `o_int`.
  - An input held high through reset produces a rising event `DEBOUNCE_CYCLES+2` cycles after reset release.
  - That event is harmless because RISE_EN=0.
  - Reset mid-count discards the count.

## Timing
- **Wishbone handshake**
  - `o_wb_ack` asserts on the edge after `i_wb_cyc & i_wb_stb & !o_wb_ack`, for exactly one cycle.
  - Back-to-back requests therefore ack every other cycle.
  - Write side effects take effect on the same edge that raises ack.
  - Read data is registered alongside ack, sampled from state before that edge.
- **Input latency:** a clean pin change at edge 0 gives `s` changing at edge 2 and `d` plus PENDING updating at edge `2+DEBOUNCE_CYCLES`.
- **Interrupt latency:** `o_int` rises in the same cycle as PENDING, provided MASK is set.
- **STATE read:** reflects `d` with no added latency beyond the registered read.

## Structure
- **Package `debounce_pkg`:** register index constants `REG_STATE=0`, `REG_PENDING=1`, `REG_MASK=2`, `REG_RISE_EN=3`, `REG_FALL_EN=4`.
- **Sub-module `debounce_cell`:** synchronizer + counter + `d`, with outputs `o_level`, `o_rise`, `o_fall`. It is parameterized by DEBOUNCE_CYCLES.
- **Top level:** instantiates N_INPUTS cells via generate and owns the registers and the Wishbone logic.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, N_INPUTS=3.
- **Clean press:** set MASK=0x7, RISE_EN=0x1; drive `i_inputs[0]` 0→1 at edge 0.
  - STATE bit0=1, PENDING=0x1 and `o_int`=1 at edge 6.
  - Reading PENDING returns 0x1.
- **Bounce:** toggle input1 high 3 cycles, low 1, high 6.
  - `d1` changes exactly once, 4 cycles after the last rise reaches `s`.
  - With FALL_EN=0x2, no event is generated.
- **W1C:** write PENDING=0x1 → PENDING=0, `o_int`=0 on the ack edge.
  - Writing 0x0 leaves pending bits unchanged.
- **Collision:** time a W1C of bit2 to land on the same edge as a falling event on input2 (FALL_EN=0x4) → PENDING bit2 remains 1.
- **Mask:** PENDING=0x2 with MASK=0 → `o_int`=0; write MASK=0x2 → `o_int`=1 on the ack edge.
  - Reads of index 5 return 0 and ack.
- **Reset mid-count:** assert `reset` while `cnt`=2 → all outputs 0 next edge.
  - After release with input still high, `d` rises at edge 6 with no interrupt.
